// File: rtl/ti_sbox_seq.sv
// ----------------------------------------------------------------------------
// ti_sbox_seq
//
// Sequencer that time-multiplexes one shared threshold-implementation 4-bit
// S-box (S = F o G) over every nibble of a SHARES-way masked state.
//
// The G and F coordinate-function banks sit outside this block and are purely
// combinational. This block does four things:
//   - feeds G one nibble per cycle
//   - owns the G->F register, which is mandatory for glitch isolation
//   - feeds F from that register
//   - writes F's result back into the state register
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, only looked at while idle
//   sh_in   in   shared state; share s nibble i at [s*4*NIB + 4*i +: 4]
//   busy    out  high from the start-accept edge until the result is done
//   done    out  one-cycle pulse, sh_out valid
//   sh_out  out  state register, same layout as sh_in
//   g_in    out  current nibble of every share (share s at [4*s +: 4])
//   g_out   in   combinational G result for g_in
//   f_in    out  G->F pipeline register contents
//   f_out   in   combinational F result for f_in
// ----------------------------------------------------------------------------
module ti_sbox_seq #(
    parameter int NIB    = 16,
    parameter int SHARES = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [4*NIB*SHARES-1:0]   sh_in,
    output logic                      busy,
    output logic                      done,
    output logic [4*NIB*SHARES-1:0]   sh_out,
    output logic [4*SHARES-1:0]       g_in,
    input  logic [4*SHARES-1:0]       g_out,
    output logic [4*SHARES-1:0]       f_in,
    input  logic [4*SHARES-1:0]       f_out
);

    localparam int SW    = 4 * NIB;
    localparam int W     = SW * SHARES;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]           fsm;
    logic [W-1:0]         state_q;
    logic [CNT_W-1:0]     cnt_p0;
    logic [4*SHARES-1:0]  mid_p1;
    logic [CNT_W-1:0]     mid_idx_p1;
    logic                 mid_vld_p1;
    logic                 busy_q;
    logic                 done_q;

    // Writeback happens for the nibble held in the G->F register:
    // in RUN once that register is valid, and unconditionally in DRAIN,
    // where it holds the last nibble. mid_idx_p1 is always below cnt_p0
    // during RUN, so G never reads a nibble that F has already rewritten.
    logic                 wr_en;
    logic [CNT_W-1:0]     wr_idx;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = mid_idx_p1;
        if (fsm == S_RUN && mid_vld_p1) begin
            wr_en = 1'b1;
        end else if (fsm == S_DRAIN) begin
            wr_en  = 1'b1;
            wr_idx = LAST;
        end
    end

    // Stage p0: read nibble cnt of every share into G.
    always_comb begin
        g_in = '0;
        for (int s = 0; s < SHARES; s++) begin
            g_in[4*s +: 4] = state_q[s*SW + 4*cnt_p0 +: 4];
        end
    end

    // Stage p1: G->F register drives F directly.
    assign f_in   = mid_p1;
    assign sh_out = state_q;
    assign busy   = busy_q;
    assign done   = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= S_IDLE;
            state_q    <= '0;
            cnt_p0     <= '0;
            mid_p1     <= '0;
            mid_idx_p1 <= '0;
            mid_vld_p1 <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (wr_en) begin
                for (int s = 0; s < SHARES; s++) begin
                    state_q[s*SW + 4*wr_idx +: 4] <= f_out[4*s +: 4];
                end
            end

            case (fsm)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= sh_in;
                        cnt_p0     <= '0;
                        mid_vld_p1 <= 1'b0;
                        busy_q     <= 1'b1;
                        fsm        <= S_RUN;
                    end
                end

                S_RUN: begin
                    mid_p1     <= g_out;
                    mid_idx_p1 <= cnt_p0;
                    mid_vld_p1 <= 1'b1;
                    if (cnt_p0 == LAST) begin
                        fsm <= S_DRAIN;
                    end else begin
                        cnt_p0 <= cnt_p0 + 1'b1;
                    end
                end

                S_DRAIN: begin
                    mid_vld_p1 <= 1'b0;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    fsm        <= S_DONE;
                end

                default: begin
                    // S_DONE: start is deliberately not looked at here.
                    done_q <= 1'b0;
                    fsm    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
